// File: rtl/dcr_mem_stage_param.sv
// MEM stage with local byte-enabled sync RAM, load formatting,
// misalignment detection, MEM/WB register and saturating counters.
module dcr_mem_stage_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [4:0]        rd_i,
  output logic [DATA_W-1:0] alu_byp_o,
  output logic              load_pending_o,
  output logic [4:0]        rd_byp_o,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_alu_o,
  output logic [DATA_W-1:0] wb_mem_o,
  output logic              wb_is_load_o,
  output logic [4:0]        wb_rd_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  load_cnt_o,
  output logic [CNT_W-1:0]  store_cnt_o,
  output logic [CNT_W-1:0]  misalign_cnt_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int BA_W  = ADDR_W + OFF_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic              acc, mis, we;
  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] idx;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] sh, fmt;

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic              wb_is_load_q, wb_is_load_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              misalign_q, misalign_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  assign acc = clken & valid_i & ~flush;
  assign off = alu_result_i[OFF_W-1:0];
  assign idx = alu_result_i[BA_W-1:OFF_W];

  assign alu_byp_o      = alu_result_i;
  assign load_pending_o = valid_i & mem_read_i & ~flush;
  assign rd_byp_o       = rd_i;

  // Alignment check, byte-lane enables and lane-replicated store data.
  always_comb begin
    int nbytes;
    nbytes = 1 << size_i;
    mis    = (nbytes > NB) || ((int'(off) & (nbytes - 1)) != 0);
    for (int i = 0; i < NB; i++)
      be[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
    unique case (size_i)
      2'b00:   wdata = {NB{store_data_i[7:0]}};
      2'b01:   wdata = {(NB/2){store_data_i[15:0]}};
      2'b10:   wdata = {(NB/4){store_data_i[31:0]}};
      default: wdata = store_data_i;
    endcase
  end

  assign we = acc & mem_write_i & ~mis & ~rst;

  // RAM: read-before-write, output held while stalled.
  always_ff @(posedge clk) begin
    if (clken) ram_q <= mem[idx];
    for (int i = 0; i < NB; i++)
      if (we && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  // Next-state for WB bundle, lane-select state and counters.
  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_alu_d     = wb_alu_q;
    wb_is_load_d = wb_is_load_q;
    wb_rd_d      = wb_rd_q;
    misalign_d   = misalign_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    ld_cnt_d     = ld_cnt_q;
    st_cnt_d     = st_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (clken) begin
      wb_valid_d   = acc;
      wb_alu_d     = alu_result_i;
      wb_is_load_d = mem_read_i;
      wb_rd_d      = rd_i;
      misalign_d   = acc & (mem_read_i | mem_write_i) & mis;
      off_d        = off;
      size_d       = size_i;
      uns_d        = unsigned_i;
    end
    if (acc && (mem_read_i || mem_write_i)) begin
      if (mis) begin
        if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
      end else if (mem_write_i) begin
        if (st_cnt_q != '1) st_cnt_d = st_cnt_q + 1'b1;
      end else begin
        if (ld_cnt_q != '1) ld_cnt_d = ld_cnt_q + 1'b1;
      end
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_alu_q     <= '0;
      wb_is_load_q <= 1'b0;
      wb_rd_q      <= '0;
      misalign_q   <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      ld_cnt_q     <= '0;
      st_cnt_q     <= '0;
      mis_cnt_q    <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_alu_q     <= wb_alu_d;
      wb_is_load_q <= wb_is_load_d;
      wb_rd_q      <= wb_rd_d;
      misalign_q   <= misalign_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      ld_cnt_q     <= ld_cnt_d;
      st_cnt_q     <= st_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  // Load formatting: select lanes, right-justify, extend.
  always_comb begin
    sh = ram_q >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   fmt = uns_q ? DATA_W'(sh[7:0])
                           : DATA_W'($signed(sh[7:0]));
      2'b01:   fmt = uns_q ? DATA_W'(sh[15:0])
                           : DATA_W'($signed(sh[15:0]));
      2'b10:   fmt = uns_q ? DATA_W'(sh[31:0])
                           : DATA_W'($signed(sh[31:0]));
      default: fmt = sh;
    endcase
  end

  assign wb_mem_o = (wb_valid_q & wb_is_load_q & ~misalign_q) ? fmt : '0;

  assign wb_valid_o     = wb_valid_q;
  assign wb_alu_o       = wb_alu_q;
  assign wb_is_load_o   = wb_is_load_q;
  assign wb_rd_o        = wb_rd_q;
  assign misalign_o     = misalign_q;
  assign load_cnt_o     = ld_cnt_q;
  assign store_cnt_o    = st_cnt_q;
  assign misalign_cnt_o = mis_cnt_q;
endmodule

// File: tb/tb_dcr_mem_stage_param.sv
// Scoreboard bench for dcr_mem_stage_param (DATA_W=32, CNT_W=4).
// Directed ops push expectations; a monitor pops on each WB valid.
module tb_dcr_mem_stage_param;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk, rst, clken, flush, valid_i;
  logic [DW-1:0] alu_result_i, store_data_i;
  logic          mem_read_i, mem_write_i, unsigned_i;
  logic [1:0]    size_i;
  logic [4:0]    rd_i;
  logic [DW-1:0] alu_byp_o, wb_alu_o, wb_mem_o;
  logic          load_pending_o, wb_valid_o, wb_is_load_o, misalign_o;
  logic [4:0]    rd_byp_o, wb_rd_o;
  logic [CW-1:0] load_cnt_o, store_cnt_o, misalign_cnt_o;

  dcr_mem_stage_param #(.DATA_W(DW), .ADDR_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .flush(flush),
    .valid_i(valid_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .rd_i(rd_i),
    .alu_byp_o(alu_byp_o), .load_pending_o(load_pending_o),
    .rd_byp_o(rd_byp_o), .wb_valid_o(wb_valid_o),
    .wb_alu_o(wb_alu_o), .wb_mem_o(wb_mem_o),
    .wb_is_load_o(wb_is_load_o), .wb_rd_o(wb_rd_o),
    .misalign_o(misalign_o), .load_cnt_o(load_cnt_o),
    .store_cnt_o(store_cnt_o), .misalign_cnt_o(misalign_cnt_o)
  );

  typedef struct {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mis;
    logic        chk_mem;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   e_ld = 0, e_st = 0, e_mis = 0;
  logic adv = 1'b0;
  logic [4:0] tag = 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) adv <= clken & ~rst;

  always @(negedge clk) begin
    if (adv && wb_valid_o) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got valid alu=%h rd=%0d, none expected",
                 wb_alu_o, wb_rd_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_alu_o !== e.alu || wb_rd_o !== e.rd ||
            misalign_o !== e.mis ||
            (e.chk_mem && wb_mem_o !== e.mem)) begin
          n_bad++;
          $display("FAIL wb_rd%0d: alu=%h rd=%0d mis=%b mem=%h, want alu=%h rd=%0d mis=%b mem=%h",
                   e.rd, wb_alu_o, wb_rd_o, misalign_o, wb_mem_o,
                   e.alu, e.rd, e.mis, e.mem);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    flush = 1'b0; clken = 1'b1;
  endtask

  function automatic int sat(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  // One op, driven at negedge; returns at the next negedge.
  task automatic op(input bit wr, input bit rdop, input bit fl,
                    input logic [1:0] sz, input bit uns,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic [31:0] exp_mem, input bit exp_mis);
    exp_t e;
    tag = tag + 5'd1;
    clken = 1'b1; valid_i = 1'b1; flush = fl;
    mem_write_i = wr; mem_read_i = rdop; size_i = sz;
    unsigned_i = uns; alu_result_i = addr; store_data_i = data;
    rd_i = tag;
    if (!fl) begin
      e.mem = exp_mem; e.alu = addr; e.rd = tag;
      e.mis = exp_mis; e.chk_mem = rdop;
      sb.push_back(e);
      if (exp_mis) e_mis = sat(e_mis);
      else if (wr) e_st = sat(e_st);
      else if (rdop) e_ld = sat(e_ld);
    end
    #1;
    chk("load_pending", {31'd0, load_pending_o}, {31'd0, rdop & ~fl});
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("cnt", {20'd0, load_cnt_o, store_cnt_o, misalign_cnt_o},
        {20'd0, CW'(e_ld), CW'(e_st), CW'(e_mis)});
  endtask

  initial begin
    rst = 1'b1; idle(); size_i = 2'b10; unsigned_i = 1'b0;
    alu_result_i = '0; store_data_i = '0; rd_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_wb", {wb_valid_o, misalign_o, wb_is_load_o, 29'd0}, 32'd0);
    chk("rst_mem", wb_mem_o, 32'd0);
    rst = 1'b0;

    op(1, 0, 0, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 0);
    // Store presented while rst is asserted: no write, all state cleared.
    valid_i = 1'b1; mem_write_i = 1'b1; size_i = 2'b10;
    alu_result_i = 32'h20; store_data_i = 32'h12345678; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; idle();
    e_ld = 0; e_st = 0; e_mis = 0;
    chk("rst_mid_wb", {wb_valid_o, misalign_o, 30'd0}, 32'd0);
    chk("rst_mid_cnt", {20'd0, load_cnt_o, store_cnt_o, misalign_cnt_o}, 32'd0);
    op(0, 1, 0, 2'b10, 0, 32'h20, 0, 32'hCAFEF00D, 0);

    op(1, 0, 0, 2'b10, 0, 32'h10, 32'h11223344, 0, 0);
    op(1, 0, 0, 2'b00, 0, 32'h12, 32'h000000AB, 0, 0);
    op(0, 1, 0, 2'b00, 0, 32'h12, 0, 32'hFFFFFFAB, 0);
    op(0, 1, 0, 2'b00, 1, 32'h12, 0, 32'h000000AB, 0);
    op(0, 1, 0, 2'b10, 0, 32'h10, 0, 32'h11AB3344, 0);

    op(0, 1, 0, 2'b01, 0, 32'h11, 0, 32'h0, 1);
    op(1, 0, 0, 2'b01, 0, 32'h11, 32'hFFFF, 0, 1);
    op(0, 1, 0, 2'b10, 0, 32'h10, 0, 32'h11AB3344, 0);
    op(0, 1, 0, 2'b11, 0, 32'h10, 0, 32'h0, 1);
    op(1, 0, 0, 2'b01, 0, 32'h12, 32'h8001, 0, 0);
    op(0, 1, 0, 2'b01, 0, 32'h12, 0, 32'hFFFF8001, 0);
    op(0, 1, 0, 2'b01, 1, 32'h12, 0, 32'h00008001, 0);
    op(0, 1, 0, 2'b10, 0, 32'h10, 0, 32'h80013344, 0);
    op(0, 1, 0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF80, 0);

    op(0, 1, 0, 2'b10, 0, 32'h10, 0, 32'h80013344, 0);
    clken = 1'b0; valid_i = 1'b1; mem_read_i = 1'b1;
    alu_result_i = 32'h20; rd_i = 5'd31;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_mem", wb_mem_o, 32'h80013344);
      chk("stall_wb", {wb_valid_o, wb_alu_o[30:0]}, {1'b1, 31'h10});
    end
    idle();

    op(1, 0, 1, 2'b10, 0, 32'h10, 32'h99, 0, 0);
    chk("flush_valid", {31'd0, wb_valid_o}, 32'd0);
    op(0, 1, 0, 2'b10, 0, 32'h10, 0, 32'h80013344, 0);

    op(1, 0, 0, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 0);
    op(0, 1, 0, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0);
    op(0, 1, 0, 2'b10, 0, 32'h400, 0, 32'hDEADBEEF, 0);
    op(1, 1, 0, 2'b10, 0, 32'h0, 32'h01020304, 32'hDEADBEEF, 0);
    op(0, 1, 0, 2'b10, 0, 32'h0, 0, 32'h01020304, 0);

    for (int i = 0; i < 20; i++)
      op(0, 1, 0, 2'b10, 0, 32'h0, 0, 32'h01020304, 0);
    chk("ld_sat", {28'd0, load_cnt_o}, 32'hF);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
